parking_gate_arbiter: RTL and testbench

Shared-barrier controller for the car parking system: several entrance lanes and one exit lane share a single barrier gate. The block arbitrates gate access, times the barrier-open window, and keeps the authoritative occupancy count. Entry is refused while the lot is full. It sits between the lane sensor/password logic, which raises requests, and the barrier actuator and status display.

---
 rtl/parking_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 46 ++++
 rtl/parking_gate_arbiter.sv | 114 +++++++++++
 tb/tb_parking_gate_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and default sizing for the parking system's barrier gate arbitration.
package parking_pkg;

  localparam int DEFAULT_N_LANES          = 2;
  localparam int DEFAULT_CAPACITY         = 8;
  localparam int DEFAULT_GATE_OPEN_CYCLES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    CLOSE = 2'd2
  } gate_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from the lane after the last winner.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         enable,
  output logic [N-1:0] grant
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] sel;
  logic [PTR_W-1:0] cand;
  logic             found;
  int               idx;

  // Grant stays zero when disabled so the pointer cannot move on a refused cycle.
  always_comb begin
    grant = '0;
    sel   = ptr;
    cand  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= N; i++) begin
      idx  = (int'(ptr) + i) % N;
      cand = PTR_W'(idx);
      if (enable && !found && req[cand]) begin
        grant[cand] = 1'b1;
        sel         = cand;
        found       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= PTR_W'(N - 1);
    end else if (found) begin
      ptr <= sel;
    end
  end

endmodule

// File: rtl/parking_gate_arbiter.sv
// Shared barrier controller: arbitrates entry/exit lanes, times the open window,
// and owns the occupancy count.
module parking_gate_arbiter
  import parking_pkg::*;
#(
  parameter  int N_LANES          = DEFAULT_N_LANES,
  parameter  int CAPACITY         = DEFAULT_CAPACITY,
  parameter  int GATE_OPEN_CYCLES = DEFAULT_GATE_OPEN_CYCLES,
  localparam int OCC_W            = $clog2(CAPACITY + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_LANES-1:0] entry_req,
  input  logic               exit_req,
  output logic [N_LANES-1:0] entry_grant,
  output logic               exit_grant,
  output logic               gate_open,
  output logic               gate_busy,
  output logic [OCC_W-1:0]   occupancy,
  output logic               full,
  output logic               empty,
  output gate_state_t        debug_state
);

  // Handshake: a requester holds its req level high until it sees its one-cycle
  // grant pulse; requests seen outside IDLE are ignored, never queued.

  localparam int              CNT_W    = (GATE_OPEN_CYCLES > 1) ? $clog2(GATE_OPEN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(GATE_OPEN_CYCLES - 1);

  gate_state_t        state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [OCC_W-1:0]   occ_next;
  logic [N_LANES-1:0] arb_grant;
  logic [N_LANES-1:0] entry_grant_next;
  logic               exit_grant_next;
  logic               exit_win;
  logic               arb_enable;

  // Exit has priority; an empty lot blocks exit, a full lot blocks entry.
  assign exit_win   = (state == IDLE) && exit_req && !empty;
  assign arb_enable = (state == IDLE) && !exit_win && !full;

  rr_arbiter #(
    .N (N_LANES)
  ) u_rr_arbiter (
    .clk    (clk),
    .rst    (reset),
    .req    (entry_req),
    .enable (arb_enable),
    .grant  (arb_grant)
  );

  always_comb begin
    state_next       = state;
    cnt_next         = cnt;
    occ_next         = occupancy;
    entry_grant_next = '0;
    exit_grant_next  = 1'b0;
    case (state)
      IDLE: begin
        if (exit_win) begin
          exit_grant_next = 1'b1;
          occ_next        = occupancy - OCC_W'(1);
          cnt_next        = CNT_LOAD;
          state_next      = OPEN;
        end else if (arb_grant != '0) begin
          entry_grant_next = arb_grant;
          occ_next         = occupancy + OCC_W'(1);
          cnt_next         = CNT_LOAD;
          state_next       = OPEN;
        end
      end
      OPEN: begin
        if (cnt == '0) begin
          state_next = CLOSE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      CLOSE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      occupancy   <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      entry_grant <= '0;
      exit_grant  <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      occupancy   <= occ_next;
      full        <= (occ_next == OCC_W'(CAPACITY));
      empty       <= (occ_next == '0);
      entry_grant <= entry_grant_next;
      exit_grant  <= exit_grant_next;
    end
  end

  assign gate_open   = (state == OPEN);
  assign gate_busy   = (state != IDLE);
  assign debug_state = state;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Self-checking bench for parking_gate_arbiter: grant scoreboard plus per-scenario
// timing, occupancy and blocking checks.
module tb_parking_gate_arbiter;
  import parking_pkg::*;

  localparam int N_LANES = 2;
  localparam int OCC_W   = 4;
  localparam int W       = 7;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [N_LANES-1:0] entry_req = '0;
  logic               exit_req = 1'b0;
  logic [N_LANES-1:0] entry_grant;
  logic               exit_grant;
  logic               gate_open;
  logic               gate_busy;
  logic [OCC_W-1:0]   occupancy;
  logic               full;
  logic               empty;
  gate_state_t        debug_state;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_v;
  logic [W-1:0] exp_v;

  parking_gate_arbiter #(
    .N_LANES          (2),
    .CAPACITY         (8),
    .GATE_OPEN_CYCLES (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .entry_req   (entry_req),
    .exit_req    (exit_req),
    .entry_grant (entry_grant),
    .exit_grant  (exit_grant),
    .gate_open   (gate_open),
    .gate_busy   (gate_busy),
    .occupancy   (occupancy),
    .full        (full),
    .empty       (empty),
    .debug_state (debug_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] pack_ev(input logic ex, input logic [1:0] en, input logic [3:0] occ);
    return {ex, en, occ};
  endfunction

  // scoreboard: every grant pulse is matched against the next expected event
  always @(negedge clk) begin
    if (!reset && (exit_grant || entry_grant != '0)) begin
      got_v = {exit_grant, entry_grant, occupancy};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL grant_unexpected got=%0h expected=none", got_v);
      end else begin
        exp_v = exp_q.pop_front();
        if (got_v !== exp_v) begin
          failures++;
          $display("FAIL grant_event got=%0h expected=%0h", got_v, exp_v);
        end
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    entry_req = '0;
    exit_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_grant(input int budget, output int cycles);
    cycles = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (exit_grant || entry_grant != '0) begin
        cycles = i;
        return;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (occupancy !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
      failures++;
      $display("FAIL reset_counts occ=%0d empty=%0b full=%0b expected occ=0 empty=1 full=0", occupancy, empty, full);
    end
    checks++;
    if (entry_grant !== 2'b00 || exit_grant !== 1'b0 || gate_open !== 1'b0 || gate_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs eg=%b xg=%b open=%b busy=%b expected all 0", entry_grant, exit_grant, gate_open, gate_busy);
    end
    checks++;
    if (debug_state !== IDLE) begin
      failures++;
      $display("FAIL reset_state got=%0d expected=%0d", debug_state, IDLE);
    end
  endtask

  task automatic test_single_entry();
    int cyc, g, b, gp;
    entry_req = 2'b01;
    exp_q.push_back(pack_ev(1'b0, 2'b01, 4'd1));
    wait_grant(20, cyc);
    entry_req = '0;
    checks++;
    if (cyc !== 1) begin
      failures++;
      $display("FAIL entry_latency got=%0d expected=1", cyc);
    end
    g = 0; b = 0; gp = 0;
    for (int i = 0; i < 8; i++) begin
      if (gate_open) g++;
      if (gate_busy) b++;
      if (entry_grant != '0) gp++;
      @(negedge clk);
    end
    checks++;
    if (g !== 4) begin
      failures++;
      $display("FAIL gate_open_cycles got=%0d expected=4", g);
    end
    checks++;
    if (b !== 5) begin
      failures++;
      $display("FAIL gate_busy_cycles got=%0d expected=5", b);
    end
    checks++;
    if (gp !== 1) begin
      failures++;
      $display("FAIL grant_pulse_width got=%0d expected=1", gp);
    end
    checks++;
    if (occupancy !== 4'd1 || empty !== 1'b0) begin
      failures++;
      $display("FAIL single_entry_occ occ=%0d empty=%0b expected occ=1 empty=0", occupancy, empty);
    end
  endtask

  task automatic test_back_to_back();
    int c0, c1;
    do_reset();
    entry_req = 2'b11;
    exp_q.push_back(pack_ev(1'b0, 2'b01, 4'd1));
    exp_q.push_back(pack_ev(1'b0, 2'b10, 4'd2));
    c0 = -1; c1 = -1;
    for (int i = 0; i < 40 && (c0 < 0 || c1 < 0); i++) begin
      @(negedge clk);
      if (entry_grant[0]) begin c0 = i; entry_req[0] = 1'b0; end
      if (entry_grant[1]) begin c1 = i; entry_req[1] = 1'b0; end
    end
    entry_req = '0;
    checks++;
    if (c0 !== 0 || c1 !== 6) begin
      failures++;
      $display("FAIL rr_spacing lane0_at=%0d lane1_at=%0d expected 0 and 6", c0, c1);
    end
    checks++;
    if (occupancy !== 4'd2) begin
      failures++;
      $display("FAIL rr_occ got=%0d expected=2", occupancy);
    end
  endtask

  task automatic test_full();
    int cyc, grants, bad;
    for (int k = 3; k <= 8; k++) begin
      entry_req = 2'b01;
      exp_q.push_back(pack_ev(1'b0, 2'b01, 4'(k)));
      wait_grant(20, cyc);
      entry_req = '0;
      checks++;
      if (cyc < 0) begin
        failures++;
        $display("FAIL fill_timeout slot=%0d got=none expected=grant", k);
      end
    end
    for (int i = 0; i < 20 && gate_busy; i++) @(negedge clk);
    checks++;
    if (occupancy !== 4'd8 || full !== 1'b1 || empty !== 1'b0) begin
      failures++;
      $display("FAIL filled occ=%0d full=%0b empty=%0b expected occ=8 full=1 empty=0", occupancy, full, empty);
    end
    entry_req = 2'b01;
    grants = 0; bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (entry_grant != '0) grants++;
      if (full !== 1'b1 || gate_busy !== 1'b0) bad++;
    end
    checks++;
    if (grants !== 0 || bad !== 0) begin
      failures++;
      $display("FAIL full_blocks grants=%0d bad_cycles=%0d expected 0 and 0", grants, bad);
    end
    exit_req = 1'b1;
    exp_q.push_back(pack_ev(1'b1, 2'b00, 4'd7));
    exp_q.push_back(pack_ev(1'b0, 2'b01, 4'd8));
    wait_grant(20, cyc);
    exit_req = 1'b0;
    checks++;
    if (exit_grant !== 1'b1 || occupancy !== 4'd7 || full !== 1'b0) begin
      failures++;
      $display("FAIL full_exit xg=%b occ=%0d full=%0b expected xg=1 occ=7 full=0", exit_grant, occupancy, full);
    end
    wait_grant(20, cyc);
    entry_req = '0;
    checks++;
    if (entry_grant !== 2'b01 || occupancy !== 4'd8 || full !== 1'b1) begin
      failures++;
      $display("FAIL pending_entry eg=%b occ=%0d full=%0b expected eg=01 occ=8 full=1", entry_grant, occupancy, full);
    end
  endtask

  task automatic test_exit_priority();
    int cyc, lane;
    logic [1:0] req;
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      lane = $urandom_range(0, 1);
      req = 2'(1 << lane);
      entry_req = req;
      exp_q.push_back(pack_ev(1'b0, req, 4'(k)));
      wait_grant(20, cyc);
      entry_req = '0;
    end
    exit_req = 1'b1;
    entry_req = 2'b10;
    exp_q.push_back(pack_ev(1'b1, 2'b00, 4'd2));
    exp_q.push_back(pack_ev(1'b0, 2'b10, 4'd3));
    wait_grant(20, cyc);
    exit_req = 1'b0;
    checks++;
    if (exit_grant !== 1'b1 || entry_grant !== 2'b00 || occupancy !== 4'd2) begin
      failures++;
      $display("FAIL exit_first xg=%b eg=%b occ=%0d expected xg=1 eg=00 occ=2", exit_grant, entry_grant, occupancy);
    end
    wait_grant(20, cyc);
    entry_req = '0;
    checks++;
    if (entry_grant !== 2'b10 || occupancy !== 4'd3) begin
      failures++;
      $display("FAIL entry_after_exit eg=%b occ=%0d expected eg=10 occ=3", entry_grant, occupancy);
    end
  endtask

  task automatic test_empty_exit();
    int bad;
    do_reset();
    exit_req = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gate_open !== 1'b0 || gate_busy !== 1'b0 || empty !== 1'b1 || exit_grant !== 1'b0) bad++;
    end
    exit_req = 1'b0;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL empty_blocks_exit bad_cycles=%0d expected=0", bad);
    end
  endtask

  task automatic test_reset_mid_open();
    int cyc;
    do_reset();
    entry_req = 2'b10;
    exp_q.push_back(pack_ev(1'b0, 2'b10, 4'd1));
    wait_grant(20, cyc);
    entry_req = '0;
    @(negedge clk);
    checks++;
    if (gate_open !== 1'b1 || debug_state !== OPEN) begin
      failures++;
      $display("FAIL pre_abort open=%b state=%0d expected open=1 state=%0d", gate_open, debug_state, OPEN);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (gate_open !== 1'b0 || gate_busy !== 1'b0 || occupancy !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
      failures++;
      $display("FAIL async_reset open=%b busy=%b occ=%0d empty=%b full=%b expected 0 0 0 1 0",
               gate_open, gate_busy, occupancy, empty, full);
    end
    checks++;
    if (debug_state !== IDLE || entry_grant !== 2'b00 || exit_grant !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_state state=%0d eg=%b xg=%b expected IDLE 00 0", debug_state, entry_grant, exit_grant);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_entry();
    test_back_to_back();
    test_full();
    test_exit_priority();
    test_empty_exit();
    test_reset_mid_open();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
